param_delay_line: RTL and testbench



---
 rtl/pdl_pkg.sv | 28 ++
 rtl/pdl_inertial_ch.sv | 79 +++++++
 rtl/param_delay_line.sv | 104 ++++++++++
 tb/tb_param_delay_line.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdl_pkg.sv
// ============================================================================
// pdl_pkg : shared types and config clamp for the param_delay_line block
// Revision 1.0
// ============================================================================
`default_nettype none

package pdl_pkg;

  typedef enum logic {
    DLY_TRANSPORT = 1'b0,
    DLY_INERTIAL  = 1'b1
  } dly_mode_e;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_PEND = 1'b1
  } ch_state_e;

  // Requested delays outside 1..max_dly are pulled to the nearest legal value.
  function automatic int pdl_clamp(input int req, input int max_dly);
    if (req < 1) return 1;
    if (req > max_dly) return max_dly;
    return req;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pdl_inertial_ch.sv
// ============================================================================
// pdl_inertial_ch : one-bit inertial filter, asks the top to copy din to dout
// Revision 1.0
// ============================================================================
`default_nettype none

module pdl_inertial_ch
  import pdl_pkg::*;
#(
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_en,
  input  logic [DW-1:0] i_delay,
  input  logic          i_din,
  input  logic          i_dout,
  output logic          o_set
);

  ch_state_e     r_state;
  ch_state_e     w_state_nxt;
  logic [DW-1:0] r_cnt;
  logic [DW-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CH_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_set       = 1'b0;
    if (i_flush || !i_en) begin
      w_state_nxt = CH_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        CH_IDLE: begin
          if (i_din != i_dout) begin
            if (i_delay == DW'(1)) begin
              o_set = 1'b1;
            end else begin
              w_state_nxt = CH_PEND;
              w_cnt_nxt   = DW'(1);
            end
          end
        end
        CH_PEND: begin
          if (i_din == i_dout) begin
            // pulse ended before reaching D samples: swallow it
            w_state_nxt = CH_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == i_delay - DW'(1)) begin
            o_set       = 1'b1;
            w_state_nxt = CH_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + DW'(1);
          end
        end
        default: begin
          w_state_nxt = CH_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/param_delay_line.sv
// ============================================================================
// param_delay_line : programmable 1..MAX_DELAY cycle transport/inertial delay
// Revision 1.0
// ============================================================================
`default_nettype none

module param_delay_line
  import pdl_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               MAX_DELAY = 16,
  parameter int               DW        = $clog2(MAX_DELAY + 1),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             cfg_load,
  input  logic [DW-1:0]    cfg_delay,
  input  logic             cfg_mode,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic [DW-1:0]    cur_delay
);

  localparam int PW = $clog2(MAX_DELAY);

  logic [WIDTH-1:0] r_buf [MAX_DELAY];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    w_rd_ptr;
  int               w_rd_sum;
  logic [DW-1:0]    r_delay;
  logic [DW-1:0]    r_busy_cnt;
  logic [DW-1:0]    w_delay_req;
  dly_mode_e        r_mode;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_buf_rd;
  logic [WIDTH-1:0] w_inert_set;
  logic [WIDTH-1:0] w_inert_nxt;

  assign w_delay_req = DW'(pdl_clamp(int'(cfg_delay), MAX_DELAY));

  // Read slot is (wr_ptr - D + 1) mod MAX_DELAY; D = 1 forwards the live write.
  always_comb begin
    w_rd_sum = int'(r_wr_ptr) + MAX_DELAY + 1 - int'(r_delay);
    if (w_rd_sum >= MAX_DELAY) w_rd_sum = w_rd_sum - MAX_DELAY;
    w_rd_ptr = PW'(w_rd_sum);
  end

  assign w_buf_rd    = (r_delay == DW'(1)) ? din : r_buf[w_rd_ptr];
  assign w_inert_nxt = (w_inert_set & din) | (~w_inert_set & r_dout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < MAX_DELAY; j++) r_buf[j] <= RESET_VAL;
      r_wr_ptr <= '0;
    end else begin
      // flush refills history with the held output; the live write still lands
      if (cfg_load) begin
        for (int j = 0; j < MAX_DELAY; j++) r_buf[j] <= r_dout;
      end
      r_buf[r_wr_ptr] <= din;
      r_wr_ptr        <= (r_wr_ptr == PW'(MAX_DELAY - 1)) ? '0 : r_wr_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_delay    <= DW'(1);
      r_mode     <= DLY_TRANSPORT;
      r_busy_cnt <= '0;
      r_dout     <= RESET_VAL;
    end else if (cfg_load) begin
      r_delay    <= w_delay_req;
      r_mode     <= dly_mode_e'(cfg_mode);
      r_busy_cnt <= w_delay_req;
    end else begin
      if (r_busy_cnt != '0) r_busy_cnt <= r_busy_cnt - DW'(1);
      r_dout <= (r_mode == DLY_TRANSPORT) ? w_buf_rd : w_inert_nxt;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_inertial_ch
    pdl_inertial_ch #(
      .DW (DW)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (cfg_load),
      .i_en    (r_mode == DLY_INERTIAL),
      .i_delay (r_delay),
      .i_din   (din[gi]),
      .i_dout  (r_dout[gi]),
      .o_set   (w_inert_set[gi])
    );
  end

  assign dout      = r_dout;
  assign busy      = (r_busy_cnt != '0);
  assign cur_delay = r_delay;

endmodule

`default_nettype wire

// File: tb/tb_param_delay_line.sv
// ============================================================================
// tb_param_delay_line : table vectors, directed corners and a queue-based model
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_param_delay_line;

  localparam int W   = 4;
  localparam int M   = 16;
  localparam int DWT = $clog2(M + 1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   din;
  logic           cfg_load;
  logic [DWT-1:0] cfg_delay;
  logic           cfg_mode;
  logic [W-1:0]   dout;
  logic           busy;
  logic [DWT-1:0] cur_delay;

  param_delay_line #(
    .WIDTH     (W),
    .MAX_DELAY (M),
    .RESET_VAL ('0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .cfg_load  (cfg_load),
    .cfg_delay (cfg_delay),
    .cfg_mode  (cfg_mode),
    .dout      (dout),
    .busy      (busy),
    .cur_delay (cur_delay)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: sample history as a queue (newest at the back)
  logic [W-1:0] m_dout;
  logic         m_mode;
  int           m_delay;
  int           m_busy;
  logic [W-1:0] m_hist[$];
  int           m_run[W];

  typedef struct {
    logic           ld;
    logic [DWT-1:0] dly;
    logic           md;
    logic [W-1:0]   d;
    logic [W-1:0]   e_dout;
    logic           e_busy;
    logic [DWT-1:0] e_cur;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_clamp(input int r);
    if (r == 0) return 1;
    if (r > M) return M;
    return r;
  endfunction

  task automatic model_reset();
    m_dout  = '0;
    m_mode  = 1'b0;
    m_delay = 1;
    m_busy  = 0;
    m_hist.delete();
    repeat (M) m_hist.push_back('0);
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    if (cfg_load) begin
      m_delay = exp_clamp(int'(cfg_delay));
      m_mode  = cfg_mode;
      m_busy  = m_delay;
      foreach (m_hist[j]) m_hist[j] = m_dout;
      void'(m_hist.pop_front());
      m_hist.push_back(din);
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      void'(m_hist.pop_front());
      m_hist.push_back(din);
      if (m_busy > 0) m_busy--;
      if (!m_mode) begin
        m_dout = m_hist[M - m_delay];
      end else begin
        for (int i = 0; i < W; i++) begin
          if (din[i] != m_dout[i]) begin
            m_run[i]++;
            if (m_run[i] >= m_delay) begin
              m_dout[i] = din[i];
              m_run[i]  = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("dout", 32'(dout), 32'(m_dout));
    chk("busy", 32'(busy), 32'(m_busy > 0));
    chk("cur_delay", 32'(cur_delay), 32'(m_delay));
  endtask

  task automatic load(input int d, input logic md, input logic [W-1:0] v);
    cfg_load  = 1'b1;
    cfg_delay = DWT'(d);
    cfg_mode  = md;
    din       = v;
    tick();
    cfg_load  = 1'b0;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    cfg_load = 1'b0;
    din      = '0;
    #2;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_len;
    rst_n = 1'b0; din = '0; cfg_load = 1'b0; cfg_delay = '0; cfg_mode = 1'b0;
    model_reset();

    tbl[0] = '{1'b1, 5'd0,  1'b0, 4'h0, 4'h0, 1'b1, 5'd1};
    tbl[1] = '{1'b0, 5'd0,  1'b0, 4'h3, 4'h3, 1'b0, 5'd1};
    tbl[2] = '{1'b0, 5'd0,  1'b0, 4'h5, 4'h5, 1'b0, 5'd1};
    tbl[3] = '{1'b1, 5'd20, 1'b0, 4'h9, 4'h5, 1'b1, 5'd16};
    tbl[4] = '{1'b1, 5'd2,  1'b0, 4'h6, 4'h5, 1'b1, 5'd2};
    tbl[5] = '{1'b0, 5'd2,  1'b0, 4'h1, 4'h6, 1'b1, 5'd2};
    tbl[6] = '{1'b0, 5'd2,  1'b0, 4'h2, 4'h1, 1'b0, 5'd2};
    tbl[7] = '{1'b0, 5'd2,  1'b0, 4'h2, 4'h2, 1'b0, 5'd2};

    #12;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cur", 32'(cur_delay), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // clamp and single-flop behaviour
    for (int r = 0; r < 8; r++) begin
      cfg_load = tbl[r].ld; cfg_delay = tbl[r].dly; cfg_mode = tbl[r].md; din = tbl[r].d;
      tick();
      chk($sformatf("tbl%0d_dout", r), 32'(dout), 32'(tbl[r].e_dout));
      chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].e_busy));
      chk($sformatf("tbl%0d_cur", r), 32'(cur_delay), 32'(tbl[r].e_cur));
    end
    cfg_load = 1'b0;

    // transport D=5, two-cycle pulse on bit 0
    hard_reset();
    load(5, 1'b0, '0);
    for (int j = 0; j < 25; j++) begin
      din = (j == 10 || j == 11) ? 4'h1 : 4'h0;
      tick();
      chk("t1_dout", 32'(dout), (j == 14 || j == 15) ? 32'h1 : 32'h0);
    end

    // inertial D=5: 3-cycle pulse swallowed, 7-cycle pulse passes
    hard_reset();
    load(5, 1'b1, '0);
    repeat (8) begin din = '0; tick(); end
    for (int j = 0; j < 13; j++) begin
      din = (j < 3) ? 4'h2 : 4'h0;
      tick();
      chk("t2_short", 32'(dout), 32'h0);
    end
    for (int j = 0; j < 16; j++) begin
      din = (j < 7) ? 4'h2 : 4'h0;
      tick();
      chk("t2_long", 32'(dout), (j >= 4 && j <= 10) ? 32'h2 : 32'h0);
    end

    // reconfigure D 3 -> 8 while dout = A
    hard_reset();
    load(3, 1'b0, '0);
    repeat (6) begin din = 4'hA; tick(); end
    chk("t4_pre", 32'(dout), 32'hA);
    load(8, 1'b0, 4'h5);
    chk("t4_hold", 32'(dout), 32'hA);
    busy_len = busy ? 1 : 0;
    for (int j = 1; j < 10; j++) begin
      din = 4'h5;
      tick();
      if (busy) busy_len++;
      chk("t4_dout", 32'(dout), (j < 7) ? 32'hA : 32'h5);
      chk("t4_busy", 32'(busy), (j <= 7) ? 32'h1 : 32'h0);
    end
    chk("t4_busy_len", 32'(busy_len), 32'd8);

    // D=16 across several pointer wraps
    hard_reset();
    load(16, 1'b0, '0);
    for (int n = 1; n < 50; n++) begin
      din = 4'(n);
      tick();
      chk("t5_wrap", 32'(dout), (n >= 15) ? 32'((n - 15) & 15) : 32'h0);
    end

    // async reset during flush and PEND
    hard_reset();
    load(2, 1'b1, '0);
    din = 4'hF; tick(); tick();
    chk("t6_pre", 32'(dout), 32'hF);
    load(5, 1'b1, 4'h0);
    din = 4'h0; tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_dout", 32'(dout), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_cur", 32'(cur_delay), 32'h1);
    model_reset();
    #2;
    rst_n = 1'b1;
    din = 4'h7;
    tick();
    chk("t6_post_dout", 32'(dout), 32'h7);
    chk("t6_post_cur", 32'(cur_delay), 32'h1);

    // randomized traffic against the model
    hard_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        load(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 4'($urandom));
      end else begin
        if ($urandom_range(0, 2) == 0) din = 4'($urandom);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
